// File: rtl/vga_sync_porch_gen.sv
// VGA raster timing: active-window strobes upstream, porch/sync-aligned blanked video downstream.
// Latency VIDEO_DELAY cycles from counter to DAC outputs; free-running, no backpressure.
module vga_sync_porch_gen #(
    parameter int VIDEO_WIDTH   = 3,
    parameter int ACTIVE_COLS   = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_WIDTH  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int ACTIVE_ROWS   = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_WIDTH  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int VIDEO_DELAY   = 3
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_Enable,
    output logic [9:0]             o_Col_Count,
    output logic [9:0]             o_Row_Count,
    output logic                   o_Pattern_HSync,
    output logic                   o_Pattern_VSync,
    output logic                   o_Frame_Start,
    input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic                   o_Active,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

    localparam int TOTAL_COLS = ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    localparam logic [9:0] LAST_COL = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] LAST_ROW = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);
    localparam logic [9:0] HS_START = 10'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [9:0] HS_END   = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [9:0] VS_START = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [9:0] VS_END   = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

    // Pipeline stage layout is {hs_n, vs_n, act}; idle is syncs deasserted, blanked.
    localparam logic [2:0] IDLE = 3'b110;

    logic       r_run;
    logic [9:0] col;
    logic [9:0] row;
    logic       hs_raw;
    logic       vs_raw;
    logic       act_raw;
    logic [2:0] raw;
    logic       act_in;

    logic [VIDEO_DELAY-1:0][2:0]   pipe;
    logic [VIDEO_WIDTH-1:0]        red_q;
    logic [VIDEO_WIDTH-1:0]        grn_q;
    logic [VIDEO_WIDTH-1:0]        blu_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_run <= 1'b0;
        end else begin
            r_run <= i_Enable;
        end
    end

    // Clearing on a low i_Enable as well makes a mid-frame stop zero the counters on the very next edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            col <= '0;
            row <= '0;
        end else if (!r_run || !i_Enable) begin
            col <= '0;
            row <= '0;
        end else if (col == LAST_COL) begin
            col <= '0;
            row <= (row == LAST_ROW) ? '0 : row + 10'd1;
        end else begin
            col <= col + 10'd1;
        end
    end

    assign o_Col_Count     = col;
    assign o_Row_Count     = row;
    assign o_Pattern_HSync = r_run && (col < ACT_COLS);
    assign o_Pattern_VSync = r_run && (row < ACT_ROWS);
    assign o_Frame_Start   = r_run && (col == '0) && (row == '0);

    assign hs_raw  = !(r_run && (col >= HS_START) && (col < HS_END));
    assign vs_raw  = !(r_run && (row >= VS_START) && (row < VS_END));
    assign act_raw = r_run && (col < ACT_COLS) && (row < ACT_ROWS);
    assign raw     = {hs_raw, vs_raw, act_raw};

    generate
        if (VIDEO_DELAY == 1) begin : g_short
            always_ff @(posedge i_Clk or negedge i_Rst_L) begin
                if (!i_Rst_L) begin
                    pipe <= {VIDEO_DELAY{IDLE}};
                end else begin
                    pipe <= raw;
                end
            end
            assign act_in = raw[0];
        end else begin : g_long
            always_ff @(posedge i_Clk or negedge i_Rst_L) begin
                if (!i_Rst_L) begin
                    pipe <= {VIDEO_DELAY{IDLE}};
                end else begin
                    pipe <= {pipe[VIDEO_DELAY-2:0], raw};
                end
            end
            assign act_in = pipe[VIDEO_DELAY-2][0];
        end
    endgenerate

    // Video is captured into the output stage only when the act bit moving into it is set.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            red_q <= '0;
            grn_q <= '0;
            blu_q <= '0;
        end else begin
            red_q <= act_in ? i_Red_Video : '0;
            grn_q <= act_in ? i_Grn_Video : '0;
            blu_q <= act_in ? i_Blu_Video : '0;
        end
    end

    assign o_HSync     = pipe[VIDEO_DELAY-1][2];
    assign o_VSync     = pipe[VIDEO_DELAY-1][1];
    assign o_Active    = pipe[VIDEO_DELAY-1][0];
    assign o_Red_Video = red_q;
    assign o_Grn_Video = grn_q;
    assign o_Blu_Video = blu_q;

endmodule
